// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader
// Description : Burst reader. Fetches 'length' words from a 1-cycle-latency
//               memory port and streams them out over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] c_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  w_last;

  assign mem_we = 1'b0;
  assign w_last = (r_idx == (r_len - c_one));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      mem_a     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              r_base  <= base_addr;
              r_len   <= length;
              r_idx   <= '0;
              mem_a   <= base_addr;
              r_state <= S_REQ;
            end else begin
              // Empty burst: skip memory entirely, just pulse done.
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          out_data  <= mem_rd;
          out_valid <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (w_last) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Address wraps naturally at 2^ADDR_WIDTH.
              r_idx   <= r_idx + c_one;
              mem_a   <= r_base + r_idx + c_one;
              r_state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
